// File: rtl/image_streamer.sv
// rtl/image_streamer.sv - buffers one image, streams it in INPUT_SIZE-wide chunks, captures the label
module image_streamer #(
  parameter int INTEGER_WIDTH  = 16,
  parameter int FRACTION_WIDTH = 16,
  parameter int NUM_PIXELS     = 10,
  parameter int INPUT_SIZE     = 1,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LABEL_WIDTH   = $clog2(NUM_CLASSES),
  localparam int AW            = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          load_valid,
  input  logic [AW-1:0]                                 load_address,
  input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] load_pixel,
  output logic                                          load_ready,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          image_ready,
  output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] pixels [INPUT_SIZE],
  input  logic                                          label_ready,
  input  logic [LABEL_WIDTH-1:0]                        label,
  output logic                                          result_valid,
  output logic [LABEL_WIDTH-1:0]                        result_label,
  output logic                                          timeout
);

  localparam int NUM_CHUNKS = (NUM_PIXELS + INPUT_SIZE - 1) / INPUT_SIZE;
  localparam int CHW        = $clog2(NUM_CHUNKS + 1);
  localparam int CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] pix_t;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [CHW-1:0]         chunk_q, chunk_d;
  logic [CW-1:0]          wait_q, wait_d;
  logic                   busy_q, busy_d;
  logic                   load_ready_q, load_ready_d;
  logic                   image_ready_q, image_ready_d;
  pix_t                   pixels_q [INPUT_SIZE];
  pix_t                   pixels_d [INPUT_SIZE];
  logic                   result_valid_q, result_valid_d;
  logic [LABEL_WIDTH-1:0] result_label_q, result_label_d;
  logic                   timeout_q, timeout_d;

  pix_t buf_q [NUM_PIXELS];
  pix_t chunk_pix [INPUT_SIZE];
  logic accept_idle;
  logic wr_en;

  // busy_q still covers the result/timeout pulse cycle, so IDLE only accepts once it drops
  assign accept_idle = (state_q == S_IDLE) && !busy_q;
  assign wr_en       = accept_idle && load_valid && (32'(load_address) < NUM_PIXELS);

  // chunk_q is 0 in IDLE; a same-cycle write is forwarded so chunk 0 includes it
  always_comb begin
    for (int i = 0; i < INPUT_SIZE; i++) begin
      int lane_idx;
      lane_idx     = int'(chunk_q) * INPUT_SIZE + i;
      chunk_pix[i] = '0;
      if (lane_idx < NUM_PIXELS) begin
        chunk_pix[i] = buf_q[AW'(lane_idx)];
        if (wr_en && (32'(load_address) == lane_idx)) chunk_pix[i] = load_pixel;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    chunk_d        = chunk_q;
    wait_d         = wait_q;
    busy_d         = busy_q;
    image_ready_d  = image_ready_q;
    pixels_d       = pixels_q;
    result_valid_d = 1'b0;
    result_label_d = result_label_q;
    timeout_d      = 1'b0;
    if (result_valid_q || timeout_q) busy_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_idle && start) begin
          state_d       = S_STREAM;
          image_ready_d = 1'b1;
          pixels_d      = chunk_pix;
          chunk_d       = CHW'(1);
          busy_d        = 1'b1;
        end
      end
      S_STREAM: begin
        if (chunk_q == CHW'(NUM_CHUNKS)) begin
          state_d       = S_WAIT;
          image_ready_d = 1'b0;
          pixels_d      = '{default: '0};
          chunk_d       = '0;
          wait_d        = '0;
        end else begin
          pixels_d = chunk_pix;
          chunk_d  = chunk_q + CHW'(1);
        end
      end
      S_WAIT: begin
        if (label_ready) begin
          state_d        = S_IDLE;
          result_label_d = label;
          result_valid_d = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    load_ready_d = !busy_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      chunk_q        <= '0;
      wait_q         <= '0;
      busy_q         <= 1'b0;
      load_ready_q   <= 1'b1;
      image_ready_q  <= 1'b0;
      pixels_q       <= '{default: '0};
      result_valid_q <= 1'b0;
      result_label_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      chunk_q        <= chunk_d;
      wait_q         <= wait_d;
      busy_q         <= busy_d;
      load_ready_q   <= load_ready_d;
      image_ready_q  <= image_ready_d;
      pixels_q       <= pixels_d;
      result_valid_q <= result_valid_d;
      result_label_q <= result_label_d;
      timeout_q      <= timeout_d;
    end
  end

  // Image buffer deliberately has no reset so a replay after reset sends the same image
  always_ff @(posedge clock) begin
    if (wr_en) buf_q[load_address] <= load_pixel;
  end

  assign load_ready   = load_ready_q;
  assign busy         = busy_q;
  assign image_ready  = image_ready_q;
  assign pixels       = pixels_q;
  assign result_valid = result_valid_q;
  assign result_label = result_label_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_image_streamer.sv
// tb/tb_image_streamer.sv - two shared-input instances (1 and 3 lanes) checked against a cycle model
module tb_image_streamer;

  localparam int NP  = 10;
  localparam int TO  = 20;
  localparam int NCA = 10;
  localparam int NCB = 4;

  typedef logic signed [15:-16] pix_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_address = '0;
  pix_t       load_pixel = '0;
  logic       start = 1'b0;
  logic       label_ready = 1'b0;
  logic [3:0] label = '0;

  logic       a_load_ready, a_busy, a_image_ready, a_result_valid, a_timeout;
  logic [3:0] a_result_label;
  pix_t       a_pixels [1];
  logic       b_load_ready, b_busy, b_image_ready, b_result_valid, b_timeout;
  logic [3:0] b_result_label;
  pix_t       b_pixels [3];

  int   passed = 0;
  int   fails = 0;
  int   total = 0;
  pix_t mem_m [NP];
  logic [3:0] prev_a = '0;
  logic [3:0] prev_b = '0;

  always #5 clock = ~clock;

  image_streamer #(.INPUT_SIZE(1), .TIMEOUT_CYCLES(TO)) dut_a (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_address(load_address),
    .load_pixel(load_pixel), .load_ready(a_load_ready), .start(start), .busy(a_busy),
    .image_ready(a_image_ready), .pixels(a_pixels), .label_ready(label_ready), .label(label),
    .result_valid(a_result_valid), .result_label(a_result_label), .timeout(a_timeout));

  image_streamer #(.INPUT_SIZE(3), .TIMEOUT_CYCLES(TO)) dut_b (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_address(load_address),
    .load_pixel(load_pixel), .load_ready(b_load_ready), .start(start), .busy(b_busy),
    .image_ready(b_image_ready), .pixels(b_pixels), .label_ready(label_ready), .label(label),
    .result_valid(b_result_valid), .result_label(b_result_label), .timeout(b_timeout));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic pix_t exp_pix(input int c, input int lanes, input int i);
    int idx;
    idx = c * lanes + i;
    return (idx < NP) ? mem_m[idx] : '0;
  endfunction

  function automatic bit label_hit(input int nc, input int lt);
    return (lt >= nc) && (lt < nc + TO);
  endfunction

  // Cycle after the WAIT_LABEL exit decision, counted from the first image_ready cycle
  function automatic int done_at(input int nc, input int lt);
    return label_hit(nc, lt) ? lt + 1 : nc + TO;
  endfunction

  task automatic chk_ctrl(input string n, input int t, input int nc, input int lt,
                          input logic [3:0] lab, input logic [3:0] prev,
                          input logic ir, input logic bz, input logic lr, input logic rv,
                          input logic tmo, input logic [3:0] rl);
    int d;
    bit hit;
    d   = done_at(nc, lt);
    hit = label_hit(nc, lt);
    chk({n, ".image_ready"}, ir, t < nc);
    chk({n, ".busy"}, bz, t <= d);
    chk({n, ".load_ready"}, lr, t > d);
    chk({n, ".result_valid"}, rv, (t == d) && hit);
    chk({n, ".timeout"}, tmo, (t == d) && !hit);
    chk({n, ".result_label"}, rl, (t >= d && hit) ? lab : prev);
  endtask

  task automatic load(input logic [3:0] a, input pix_t p);
    load_valid   = 1'b1;
    load_address = a;
    load_pixel   = p;
    tick();
    load_valid = 1'b0;
    if (a < NP) mem_m[a] = p;
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, ".a_image_ready"}, a_image_ready, 1'b0);
    chk({n, ".a_busy"}, a_busy, 1'b0);
    chk({n, ".a_load_ready"}, a_load_ready, 1'b1);
    chk({n, ".a_result_valid"}, a_result_valid, 1'b0);
    chk({n, ".a_timeout"}, a_timeout, 1'b0);
    chk({n, ".a_result_label"}, a_result_label, 4'd0);
    chk({n, ".a_pix"}, a_pixels[0], '0);
    chk({n, ".b_image_ready"}, b_image_ready, 1'b0);
    chk({n, ".b_busy"}, b_busy, 1'b0);
    chk({n, ".b_load_ready"}, b_load_ready, 1'b1);
    for (int i = 0; i < 3; i++) chk({n, ".b_pix"}, b_pixels[i], '0);
  endtask

  // lt: cycle label_ready is high; fwd: write issued with start; inj: start+write during stream
  task automatic run(input int lt, input logic [3:0] lab, input int fwd, input pix_t fwd_pix,
                     input int inj, input int rst_t);
    int  dmax;
    bit  aborted;
    aborted = 1'b0;
    if (fwd >= 0) begin
      load_valid   = 1'b1;
      load_address = 4'(fwd);
      load_pixel   = fwd_pix;
      mem_m[fwd]   = fwd_pix;
    end
    start = 1'b1;
    tick();
    start      = 1'b0;
    load_valid = 1'b0;
    dmax = (done_at(NCA, lt) > done_at(NCB, lt)) ? done_at(NCA, lt) : done_at(NCB, lt);
    for (int t = 0; t <= dmax + 1; t++) begin
      chk_ctrl("a", t, NCA, lt, lab, prev_a, a_image_ready, a_busy, a_load_ready,
               a_result_valid, a_timeout, a_result_label);
      chk_ctrl("b", t, NCB, lt, lab, prev_b, b_image_ready, b_busy, b_load_ready,
               b_result_valid, b_timeout, b_result_label);
      chk("a.pixels", a_pixels[0], exp_pix(t, 1, 0));
      for (int i = 0; i < 3; i++) chk("b.pixels", b_pixels[i], exp_pix(t, 3, i));
      if (t == rst_t) begin
        label_ready = 1'b0;
        #2 reset = 1'b0;
        #1 chk_reset_vals("midrst");
        #1 reset = 1'b1;
        tick();
        aborted = 1'b1;
        break;
      end
      label_ready = (t == lt);
      label       = (t == lt) ? lab : 4'($urandom_range(0, 15));
      if (t == inj) begin
        start        = 1'b1;
        load_valid   = 1'b1;
        load_address = 4'd0;
        load_pixel   = 32'sd5 <<< 16;
      end else begin
        start      = 1'b0;
        load_valid = 1'b0;
      end
      tick();
    end
    label_ready = 1'b0;
    start       = 1'b0;
    load_valid  = 1'b0;
    if (aborted) begin
      prev_a = '0;
      prev_b = '0;
    end else begin
      if (label_hit(NCA, lt)) prev_a = lab;
      if (label_hit(NCB, lt)) prev_b = lab;
    end
  endtask

  initial begin
    tick();
    chk_reset_vals("reset");
    #3 reset = 1'b1;
    tick();
    chk_reset_vals("idle");

    for (int i = 0; i < NP; i++) load(4'(i), pix_t'(i) <<< 16);
    load(4'd12, 32'hDEAD_BEEF);
    run(11, 4'd7, -1, '0, -1, -1);

    for (int i = 0; i < NP; i++) load(4'(i), pix_t'($urandom));
    run(2, 4'($urandom_range(0, 9)), 3, pix_t'($urandom), 1, -1);
    run($urandom_range(10, 25), 4'($urandom_range(0, 9)), -1, '0, -1, -1);

    run(-1, 4'd0, -1, '0, -1, 3);
    run($urandom_range(10, 20), 4'($urandom_range(0, 9)), -1, '0, -1, -1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NP; i++) load(4'(i), pix_t'($urandom));
      run($urandom_range(0, 34), 4'($urandom_range(0, 9)),
          $urandom_range(0, 1) ? $urandom_range(0, 9) : -1, pix_t'($urandom), -1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
